// File: rtl/axi_aw_w_arbiter.sv
// Round-robin AW arbiter for one crossbar master port. A W-order FIFO of granted
// requester indices steers the W channel from the owning requester until WLAST.
module axi_aw_w_arbiter #(
  parameter int NB_SLAVE     = 4,
  parameter int AXI_ID_WIDTH = 10,
  parameter int AW_PAYLOAD_W = 64,
  parameter int W_PAYLOAD_W  = 37,
  parameter int W_FIFO_DEPTH = 4,
  localparam int IDX_W       = $clog2(NB_SLAVE),
  localparam int AXI_ID_OUT  = AXI_ID_WIDTH + IDX_W
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NB_SLAVE-1:0]                      aw_valid_i,
  output logic [NB_SLAVE-1:0]                      aw_ready_o,
  input  logic [NB_SLAVE-1:0][AXI_ID_WIDTH-1:0]    aw_id_i,
  input  logic [NB_SLAVE-1:0][AW_PAYLOAD_W-1:0]    aw_payload_i,
  output logic                                     aw_valid_o,
  input  logic                                     aw_ready_i,
  output logic [AXI_ID_OUT-1:0]                    aw_id_o,
  output logic [AW_PAYLOAD_W-1:0]                  aw_payload_o,
  input  logic [NB_SLAVE-1:0]                      w_valid_i,
  output logic [NB_SLAVE-1:0]                      w_ready_o,
  input  logic [NB_SLAVE-1:0][W_PAYLOAD_W-1:0]     w_payload_i,
  input  logic [NB_SLAVE-1:0]                      w_last_i,
  output logic                                     w_valid_o,
  input  logic                                     w_ready_i,
  output logic [W_PAYLOAD_W-1:0]                   w_payload_o,
  output logic                                     w_last_o
);

  localparam int PTR_W = (W_FIFO_DEPTH > 1) ? $clog2(W_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(W_FIFO_DEPTH + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, lock_q, rr_sel, aw_sel, head;
  logic              rr_found, aw_hs, w_pop, fifo_full, fifo_empty;
  logic [IDX_W-1:0]  fifo_mem [W_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NB_SLAVE - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(W_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count_q == CNT_W'(W_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int j;
    logic [IDX_W-1:0] cand;
    rr_sel   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NB_SLAVE; i++) begin
      j    = (int'(rr_q) + i) % NB_SLAVE;
      cand = IDX_W'(j);
      if (!rr_found && aw_valid_i[cand]) begin
        rr_sel   = cand;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    aw_sel       = rr_sel;
    aw_valid_o   = 1'b0;
    aw_ready_o   = '0;
    aw_id_o      = '0;
    aw_payload_o = '0;
    aw_hs        = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (rr_found && !fifo_full) begin
            aw_valid_o = 1'b1;
            if (!aw_ready_i) state_d = HOLD;
          end
        end
        HOLD: begin
          // Keep presenting the locked requester until it is accepted.
          aw_sel     = lock_q;
          aw_valid_o = aw_valid_i[lock_q];
          if (aw_valid_o && aw_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (aw_valid_o) begin
        aw_id_o            = {aw_sel, aw_id_i[aw_sel]};
        aw_payload_o       = aw_payload_i[aw_sel];
        aw_ready_o[aw_sel] = aw_ready_i;
        aw_hs              = aw_ready_i;
      end
    end
  end

  always_comb begin
    w_valid_o   = 1'b0;
    w_ready_o   = '0;
    w_payload_o = '0;
    w_last_o    = 1'b0;
    w_pop       = 1'b0;
    if (!rst && !fifo_empty) begin
      w_valid_o       = w_valid_i[head];
      w_payload_o     = w_payload_i[head];
      w_last_o        = w_last_i[head];
      w_ready_o[head] = w_ready_i;
      w_pop           = w_valid_o && w_ready_i && w_last_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == HOLD) lock_q <= rr_sel;
      if (aw_hs) rr_q <= next_idx(aw_sel);
    end
  end

  // W-order FIFO control; entries are only read while count_q is non-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (aw_hs) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (w_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({aw_hs, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) fifo_mem[wr_ptr_q] <= aw_sel;
  end

endmodule

// File: tb/tb_axi_aw_w_arbiter.sv
// Directed bench for axi_aw_w_arbiter: a cycle-by-cycle vector table plus
// hand-written reset, ID and asynchronous-reset sequences.
module tb_axi_aw_w_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        aw_valid_i, aw_ready_o;
  logic [3:0][9:0]   aw_id_i;
  logic [3:0][63:0]  aw_payload_i;
  logic              aw_valid_o, aw_ready_i;
  logic [11:0]       aw_id_o;
  logic [63:0]       aw_payload_o;
  logic [3:0]        w_valid_i, w_ready_o, w_last_i;
  logic [3:0][36:0]  w_payload_i;
  logic              w_valid_o, w_ready_i, w_last_o;
  logic [36:0]       w_payload_o;

  int n_chk  = 0;
  int n_fail = 0;

  axi_aw_w_arbiter #(
    .NB_SLAVE(4), .AXI_ID_WIDTH(10), .AW_PAYLOAD_W(64), .W_PAYLOAD_W(37), .W_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_payload_i(aw_payload_i), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .aw_id_o(aw_id_o), .aw_payload_o(aw_payload_o),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_payload_i(w_payload_i),
    .w_last_i(w_last_i), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .w_payload_o(w_payload_o), .w_last_o(w_last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] awv;
    logic       awr;
    logic [3:0] wv;
    logic [3:0] wl;
    logic       wr;
    logic       e_awv;
    logic [1:0] e_g;
    logic       e_wact;
    logic [1:0] e_h;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] awv, input logic awr, input logic [3:0] wv,
                              input logic [3:0] wl, input logic wr, input logic e_awv,
                              input logic [1:0] e_g, input logic e_wact, input logic [1:0] e_h);
    vec_t v;
    v.awv = awv; v.awr = awr; v.wv = wv; v.wl = wl; v.wr = wr;
    v.e_awv = e_awv; v.e_g = e_g; v.e_wact = e_wact; v.e_h = e_h;
    return v;
  endfunction

  function automatic logic [9:0]  id_of(input logic [1:0] i);  return 10'h100 + 10'(i); endfunction
  function automatic logic [63:0] awp_of(input logic [1:0] i); return 64'hCAFE_0000_0000_0000 + 64'(i); endfunction
  function automatic logic [36:0] wp_of(input logic [1:0] i);  return 37'h0A_0000_0000 + 37'(i); endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    aw_valid_i = v.awv; aw_ready_i = v.awr;
    w_valid_i  = v.wv;  w_last_i   = v.wl;  w_ready_i = v.wr;
  endtask

  task automatic check_vec(input vec_t v, input int k);
    logic [3:0] one_g, one_h;
    one_g = 4'b0001 << v.e_g;
    one_h = 4'b0001 << v.e_h;
    chk($sformatf("v%0d aw_valid_o", k), 64'(aw_valid_o), 64'(v.e_awv));
    if (v.e_awv) begin
      chk($sformatf("v%0d aw_id_o", k), 64'(aw_id_o), 64'({v.e_g, id_of(v.e_g)}));
      chk($sformatf("v%0d aw_payload_o", k), aw_payload_o, awp_of(v.e_g));
      chk($sformatf("v%0d aw_ready_o", k), 64'(aw_ready_o), 64'(v.awr ? one_g : 4'b0000));
    end else begin
      chk($sformatf("v%0d aw_ready_o idle", k), 64'(aw_ready_o), 64'd0);
    end
    chk($sformatf("v%0d w_valid_o", k), 64'(w_valid_o), 64'(v.e_wact & v.wv[v.e_h]));
    chk($sformatf("v%0d w_ready_o", k), 64'(w_ready_o), 64'((v.e_wact && v.wr) ? one_h : 4'b0000));
    if (v.e_wact) begin
      chk($sformatf("v%0d w_last_o", k), 64'(w_last_o), 64'(v.wl[v.e_h]));
      chk($sformatf("v%0d w_payload_o", k), 64'(w_payload_o), 64'(wp_of(v.e_h)));
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      aw_id_i[i]      = id_of(2'(i));
      aw_payload_i[i] = awp_of(2'(i));
      w_payload_i[i]  = wp_of(2'(i));
    end

    // Round-robin fairness with W draining one beat per cycle.
    tbl.push_back(mk(4'hF, 1, 4'h0, 4'h0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 4'hF, 4'hF, 1, 1, 1, 1, 0));
    tbl.push_back(mk(4'hF, 1, 4'hF, 4'hF, 1, 1, 2, 1, 1));
    tbl.push_back(mk(4'hF, 1, 4'hF, 4'hF, 1, 1, 3, 1, 2));
    tbl.push_back(mk(4'hF, 1, 4'hF, 4'hF, 1, 1, 0, 1, 3));
    tbl.push_back(mk(4'hF, 1, 4'hF, 4'hF, 1, 1, 1, 1, 0));
    tbl.push_back(mk(4'hF, 1, 4'hF, 4'hF, 1, 1, 2, 1, 1));
    tbl.push_back(mk(4'hF, 1, 4'hF, 4'hF, 1, 1, 3, 1, 2));
    tbl.push_back(mk(4'h0, 0, 4'hF, 4'hF, 1, 0, 0, 1, 3));
    // Hold: requester 1 stays granted after requester 0 rises, then 2,3,0.
    tbl.push_back(mk(4'h2, 0, 4'h0, 4'h0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(4'h2, 0, 4'h0, 4'h0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(4'h2, 0, 4'h0, 4'h0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(4'h3, 0, 4'h0, 4'h0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(4'h3, 1, 4'h0, 4'h0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(4'hD, 1, 4'hF, 4'hF, 1, 1, 2, 1, 1));
    tbl.push_back(mk(4'hD, 1, 4'hF, 4'hF, 1, 1, 3, 1, 2));
    tbl.push_back(mk(4'hD, 1, 4'hF, 4'hF, 1, 1, 0, 1, 3));
    tbl.push_back(mk(4'h0, 0, 4'hF, 4'hF, 1, 0, 0, 1, 0));
    // W ordering: grants 2 then 0; requester 0 W waits behind 2's four beats.
    tbl.push_back(mk(4'h4, 1, 4'h0, 4'h0, 0, 1, 2, 0, 0));
    tbl.push_back(mk(4'h1, 1, 4'h1, 4'h1, 1, 1, 0, 1, 2));
    tbl.push_back(mk(4'h0, 0, 4'h5, 4'h1, 1, 0, 0, 1, 2));
    tbl.push_back(mk(4'h0, 0, 4'h5, 4'h1, 1, 0, 0, 1, 2));
    tbl.push_back(mk(4'h0, 0, 4'h5, 4'h1, 1, 0, 0, 1, 2));
    tbl.push_back(mk(4'h0, 0, 4'h5, 4'h5, 1, 0, 0, 1, 2));
    tbl.push_back(mk(4'h0, 0, 4'h1, 4'h1, 1, 0, 0, 1, 0));
    // FIFO full: four grants, fifth blocked, no bypass on the popping cycle.
    tbl.push_back(mk(4'hF, 1, 4'h0, 4'h0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(4'hF, 1, 4'h0, 4'h0, 0, 1, 2, 1, 1));
    tbl.push_back(mk(4'hF, 1, 4'h0, 4'h0, 0, 1, 3, 1, 1));
    tbl.push_back(mk(4'hF, 1, 4'h0, 4'h0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(4'hF, 1, 4'h0, 4'h0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'hF, 1, 4'h2, 4'h2, 1, 0, 0, 1, 1));
    tbl.push_back(mk(4'hF, 1, 4'h0, 4'h0, 0, 1, 1, 1, 2));

    // Reset with every requester valid: all outputs quiet.
    rst = 1'b1;
    aw_valid_i = 4'hF; aw_ready_i = 1'b1;
    w_valid_i = 4'hF; w_last_i = 4'hF; w_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst aw_valid_o", 64'(aw_valid_o), 64'd0);
    chk("rst aw_ready_o", 64'(aw_ready_o), 64'd0);
    chk("rst aw_id_o", 64'(aw_id_o), 64'd0);
    chk("rst aw_payload_o", aw_payload_o, 64'd0);
    chk("rst w_valid_o", 64'(w_valid_o), 64'd0);
    chk("rst w_ready_o", 64'(w_ready_o), 64'd0);
    chk("rst w_last_o", 64'(w_last_o), 64'd0);
    chk("rst w_payload_o", 64'(w_payload_o), 64'd0);

    // Release: requester 0 wins first (no handshake taken).
    rst = 1'b0; aw_ready_i = 1'b0; w_valid_i = 4'h0; w_last_i = 4'h0; w_ready_i = 1'b0;
    #3;
    chk("post-rst aw_valid_o", 64'(aw_valid_o), 64'd1);
    chk("post-rst aw_id_o", 64'(aw_id_o), 64'({2'd0, id_of(2'd0)}));
    chk("post-rst w_valid_o", 64'(w_valid_o), 64'd0);
    aw_valid_i = 4'h0;
    @(posedge clk); #1;

    // ID prefix: requester 3 with ID 2A5.
    aw_id_i[3] = 10'h2A5; aw_valid_i = 4'b1000; aw_ready_i = 1'b1;
    #3;
    chk("id aw_id_o", 64'(aw_id_o), 64'h0EA5);
    chk("id aw_ready_o", 64'(aw_ready_o), 64'h8);
    @(posedge clk); #1;
    aw_id_i[3] = id_of(2'd3); aw_valid_i = 4'h0; aw_ready_i = 1'b0;
    w_valid_i = 4'b1000; w_last_i = 4'b1000; w_ready_i = 1'b1;
    #3;
    chk("id w_valid_o", 64'(w_valid_o), 64'd1);
    chk("id w_ready_o", 64'(w_ready_o), 64'h8);
    chk("id w_last_o", 64'(w_last_o), 64'd1);
    @(posedge clk); #1;

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k]);
      #3;
      check_vec(tbl[k], k);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-burst between clock edges clears FIFO and pointer.
    aw_valid_i = 4'hF; aw_ready_i = 1'b0;
    w_valid_i = 4'hF; w_last_i = 4'h0; w_ready_i = 1'b0;
    #1;
    chk("pre-arst aw_valid_o full", 64'(aw_valid_o), 64'd0);
    chk("pre-arst w_valid_o", 64'(w_valid_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst aw_valid_o", 64'(aw_valid_o), 64'd0);
    chk("arst w_valid_o", 64'(w_valid_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("after arst aw_valid_o", 64'(aw_valid_o), 64'd1);
    chk("after arst aw_id_o", 64'(aw_id_o), 64'({2'd0, id_of(2'd0)}));
    chk("after arst w_valid_o", 64'(w_valid_o), 64'd0);
    chk("after arst w_ready_o", 64'(w_ready_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
